// File: rtl/ram_loader.sv
// Streams 2^ADDR_WIDTH words into a RAM and optionally reads them back to compare checksums.
// Write lands one cycle after accept (1 word/cycle); byte_ready is high only in LOAD, so the source just holds valid.
module ram_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int VERIFY     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RD_ISSUE,
    RD_CHECK,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic                  accept;
  logic                  clear;
  logic [ADDR_WIDTH-1:0] wcnt, rcnt;
  logic [DATA_WIDTH-1:0] wsum, rsum, rsum_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = LOAD;
          clear     = 1'b1;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        accept     = byte_valid;
        if (byte_valid && (wcnt == LAST_ADDR)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy      = 1'b1;
        state_nxt = (VERIFY != 0) ? RD_ISSUE : DONE;
      end
      RD_ISSUE: begin
        busy      = 1'b1;
        state_nxt = RD_CHECK;
      end
      RD_CHECK: begin
        busy      = 1'b1;
        state_nxt = (rcnt == LAST_ADDR) ? DONE : RD_ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_hold = busy;
  assign rsum_nxt = rsum + ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      wsum      <= '0;
      rsum      <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      ram_we <= accept;
      if (clear) begin
        wcnt  <= '0;
        rcnt  <= '0;
        wsum  <= '0;
        rsum  <= '0;
        done  <= 1'b0;
        error <= 1'b0;
      end
      if (accept) begin
        ram_addr  <= wcnt;
        ram_wdata <= byte_data;
        wcnt      <= wcnt + 1'b1;
        wsum      <= wsum + byte_data;
      end
      // Read address is registered so it is on the bus for the whole RD_ISSUE cycle.
      if (state_nxt == RD_ISSUE) begin
        ram_addr <= (state == RD_CHECK) ? rcnt + 1'b1 : rcnt;
      end
      if (state == RD_CHECK) begin
        rsum <= rsum_nxt;
        rcnt <= rcnt + 1'b1;
      end
      if ((state != DONE) && (state_nxt == DONE)) begin
        done  <= 1'b1;
        error <= (VERIFY != 0) ? (rsum_nxt != wsum) : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboarded bench for ram_loader: behavioural RAM, randomised source, separate write monitor.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, byte_valid;
  logic [7:0] byte_data, ram_wdata, ram_rdata;
  logic [3:0] ram_addr;
  logic       byte_ready, ram_we, cpu_hold, busy, done, error;

  logic       nv_start, nv_valid, nv_ready, nv_we, nv_hold, nv_busy, nv_done, nv_error;
  logic [7:0] nv_data = 8'hFF;
  logic [7:0] nv_rdata = 8'h00;
  logic [7:0] nv_wdata;
  logic [3:0] nv_addr;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .VERIFY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .VERIFY(0)) u_nv (
    .clk(clk), .rst_n(rst_n), .start(nv_start), .byte_valid(nv_valid), .byte_data(nv_data),
    .byte_ready(nv_ready), .ram_we(nv_we), .ram_addr(nv_addr), .ram_wdata(nv_wdata),
    .ram_rdata(nv_rdata), .cpu_hold(nv_hold), .busy(nv_busy), .done(nv_done), .error(nv_error)
  );

  // RAM with a one-cycle read and an optional stuck bit on address 5.
  logic [7:0] mem [16];
  bit         corrupt = 1'b0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] ^ ((corrupt && ram_addr == 4'd5) ? 8'h01 : 8'h00);
  end

  int         checks = 0;
  int         errors = 0;
  int         rst_cnt = 0;
  logic [11:0] exp_q[$];
  logic [7:0] words [16];

  always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every write must follow an accept one cycle earlier and carry the next expected (addr, word).
  initial begin : monitor
    logic [11:0] e;
    bit          acc_prev;
    int          rst_prev;
    acc_prev = 1'b0;
    rst_prev = 0;
    forever begin
      @(negedge clk);
      if (rst_n && rst_cnt == rst_prev) begin
        chk("we_follows_accept", ram_we, acc_prev);
        if (ram_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {ram_addr, ram_wdata}, 12'hFFF);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr_data", {ram_addr, ram_wdata}, e);
          end
        end
      end
      acc_prev = byte_valid & byte_ready;
      rst_prev = rst_cnt;
    end
  end

  function automatic bit model_error();
    logic [7:0] sw, sr;
    sw = 8'h00;
    sr = 8'h00;
    for (int i = 0; i < 16; i++) begin
      sw = sw + words[i];
      sr = sr + (words[i] ^ ((corrupt && i == 5) ? 8'h01 : 8'h00));
    end
    return sw != sr;
  endfunction

  function automatic logic pick_valid(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: continuous, 1: toggling, 2: random. abort_at>0 resets after that many accepts.
  task automatic run_load(input int mode, input bit pulses, input int abort_at, output int cyc);
    int k, guard;
    bit rdy;
    k = 0;
    guard = 0;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    byte_valid = pick_valid(mode, 0);
    byte_data = words[0];
    while (k < 16 && guard < 400) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      cyc++;
      guard++;
      if (byte_valid && rdy) begin
        exp_q.push_back({4'(k), words[k]});
        k++;
      end
      if (abort_at > 0 && k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_byte_ready", byte_ready, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 4'h0);
        chk("rst_ram_wdata", ram_wdata, 8'h00);
        chk("rst_hold_busy", {cpu_hold, busy}, 2'b00);
        chk("rst_done_error", {done, error}, 2'b00);
        start = 1'b0;
        byte_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {busy, byte_ready, done}, 3'b000);
        return;
      end
      #1;
      start = pulses ? ($urandom_range(0, 3) == 0) : 1'b0;
      byte_valid = (k < 16) ? pick_valid(mode, guard) : 1'b0;
      byte_data = (k < 16) ? words[k] : 8'($urandom);
    end
    start = 1'b0;
    byte_valid = 1'b0;
    chk("load_finished", 32'(k), 32'd16);
    guard = 0;
    forever begin
      @(negedge clk);
      if (done || guard >= 200) break;
      @(posedge clk);
      cyc++;
      guard++;
    end
    chk("done_within_bound", done, 1'b1);
  endtask

  task automatic end_checks();
    chk("done_set", done, 1'b1);
    chk("error_flag", error, model_error());
    chk("hold_busy_low", {cpu_hold, busy, byte_ready}, 3'b000);
    chk("done_addr_held", ram_addr, 4'hF);
    chk("done_wdata_held", ram_wdata, words[15]);
    chk("done_no_we", ram_we, 1'b0);
  endtask

  initial begin
    int cyc, wr;
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    nv_start = 1'b0;
    nv_valid = 1'b0;
    #12;
    chk("reset_outputs", {byte_ready, ram_we, cpu_hold, busy, done, error}, 6'b0);
    chk("reset_addr_data", {ram_addr, ram_wdata}, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", {busy, byte_ready, done}, 3'b000);

    // Continuous 0x01..0x10: done lands 50 edges after the start edge.
    for (int i = 0; i < 16; i++) words[i] = 8'(i + 1);
    run_load(0, 1'b0, 0, cyc);
    chk("continuous_cycles", 32'(cyc), 32'd50);
    end_checks();

    // Toggling valid, random data.
    for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    run_load(1, 1'b0, 0, cyc);
    end_checks();

    // Corrupted read-back, random valid, stray start pulses during load.
    for (int i = 0; i < 16; i++) words[i] = 8'(i + 1);
    corrupt = 1'b1;
    run_load(2, 1'b1, 0, cyc);
    end_checks();
    corrupt = 1'b0;

    // Source keeps offering words in DONE: must be ignored.
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data = 8'hA5;
    repeat (6) @(negedge clk);
    chk("done_ignores_valid", {done, busy, ram_we, ram_addr}, {3'b100, 4'hF});
    @(posedge clk); #1 byte_valid = 1'b0;

    // Abort after 7 accepts, then a full random load from address 0.
    for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    run_load(2, 1'b0, 7, cyc);
    for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    run_load(2, 1'b0, 0, cyc);
    end_checks();

    // VERIFY=0 instance: 16 x 0xFF, DONE straight after FLUSH.
    wr = 0;
    cyc = 0;
    @(posedge clk); #1;
    nv_start = 1'b1;
    nv_valid = 1'b1;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (nv_we) begin
        chk("nv_write", {nv_addr, nv_wdata}, {4'(wr), 8'hFF});
        wr++;
      end
      if (nv_done) break;
      @(posedge clk);
      cyc++;
      #1 nv_start = 1'b0;
    end
    chk("nv_cycles", 32'(cyc), 32'd18);
    repeat (4) begin
      @(negedge clk);
      if (nv_we) wr++;
    end
    chk("nv_write_count", 32'(wr), 32'd16);
    chk("nv_status", {nv_done, nv_error, nv_busy, nv_hold, nv_ready}, 5'b10000);
    nv_valid = 1'b0;

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set RAM address width; the block loads 2^ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set word width.
REQ-003 Parameter VERIFY, default 1, SHALL enable (1) or skip (0) the read-back check pass.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 start  in  1  SHALL request a load sequence; sampled only in IDLE or DONE.
REQ-007 byte_valid  in  1  SHALL mark byte_data as valid from the source.
REQ-008 byte_data  in  DATA_WIDTH  SHALL carry the next program/data word.
REQ-009 byte_ready  out  1  SHALL indicate the loader accepts a word this cycle.
REQ-010 ram_we  out  1  SHALL be the RAM write_enable.
REQ-011 ram_addr  out  ADDR_WIDTH  SHALL be the RAM address.
REQ-012 ram_wdata  out  DATA_WIDTH  SHALL be the RAM data_in.
REQ-013 ram_rdata  in  DATA_WIDTH  SHALL be the RAM data_out, valid one cycle after ram_addr is presented with ram_we=0.
REQ-014 cpu_hold  out  1  SHALL hold the SAP-1 CPU while loading.
REQ-015 busy  out  1, done  out  1, error  out  1  SHALL report status.

Function
REQ-016 States SHALL be IDLE, LOAD, FLUSH, RD_ISSUE, RD_CHECK, DONE.
REQ-017 IDLE/DONE + start=1 SHALL go to LOAD next cycle, clearing wcnt, rcnt, wsum, rsum, done, error.
REQ-018 byte_ready SHALL equal 1 exactly in LOAD; a word is accepted on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 On accept, the next cycle SHALL drive ram_we=1, ram_addr=wcnt, ram_wdata=accepted word; wcnt increments; wsum += word (mod 2^DATA_WIDTH).
REQ-020 ram_we SHALL be 0 on every cycle not following an accept; back-to-back accepts yield back-to-back writes (1 word/cycle).
REQ-021 Accept with wcnt=2^ADDR_WIDTH-1 SHALL go to FLUSH (last write issued in FLUSH); wcnt wraps to 0; no further words accepted.
REQ-022 FLUSH SHALL last one cycle, then go to RD_ISSUE if VERIFY=1, else DONE.
REQ-023 RD_ISSUE SHALL drive ram_we=0, ram_addr=rcnt, then go to RD_CHECK.
REQ-024 RD_CHECK SHALL add ram_rdata to rsum, increment rcnt, return to RD_ISSUE, or go to DONE after rcnt=2^ADDR_WIDTH-1 (2 cycles/word).
REQ-025 Entering DONE with VERIFY=1 SHALL set error=1 iff final rsum != wsum; VERIFY=0 SHALL leave error=0.
REQ-026 busy and cpu_hold SHALL be 1 in LOAD, FLUSH, RD_ISSUE, RD_CHECK; 0 in IDLE and DONE.
REQ-027 done SHALL be 1 in DONE and stay set until the next start or reset; error holds likewise.
REQ-028 start while busy SHALL be ignored; byte_valid outside LOAD SHALL be ignored.
REQ-029 In IDLE/DONE, ram_addr and ram_wdata SHALL hold last values, ram_we=0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, byte_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=0, busy=0, done=0, error=0, all counters and sums 0.
REQ-031 Reset mid-sequence SHALL abort without completing the in-flight write; partial RAM contents are not restored.
REQ-032 After release, the block SHALL stay in IDLE until start=1.

Verification
REQ-033 Continuous stream 0x01..0x10, byte_valid=1 -> 16 writes addr 0..15 on consecutive cycles, wsum=0x88, matching RAM read-back -> done=1, error=0, cpu_hold low after 1+16+1+32 cycles.
REQ-034 byte_valid toggling 1/0 each cycle -> ram_we pulses only after accepts, addresses strictly sequential, no gaps or duplicates.
REQ-035 RAM model corrupts addr 5 (0x06->0x07) on read -> done=1, error=1.
REQ-036 rst_n=0 after 7 accepts -> all outputs zero asynchronously; new start restarts at addr 0.
REQ-037 start pulsed during LOAD, and byte_valid in DONE -> no state change, no ram_we.
REQ-038 VERIFY=0, 16 words 0xFF -> DONE on cycle after FLUSH, no read cycles, error=0.
